cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter ADDR_W, 12, memory word-address width.
REQ-002 Parameter DATA_W, 32, memory data width.
REQ-003 Parameter RST_CYCLES, 2, cycles cpu_clr is held high before each run; must be at least 1.
REQ-004 Parameter TIMEOUT, 100, maximum RUN cycles before forced stop; must be at least 1.
REQ-005 Parameter TOHOST_ADDR, 12'hFFF, word address whose store ends the run.
REQ-006 Parameter CYC_W, 32, cycle counter width; TIMEOUT < 2^CYC_W.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 clr  in  1  reset is synchronous and active-low.
REQ-009 ld_valid  in  1  program-load beat valid.
REQ-010 ld_ready  out  1  load beat accepted when ld_valid and ld_ready are both high.
REQ-011 ld_addr  in  ADDR_W  word address of the load beat.
REQ-012 ld_data  in  DATA_W  data of the load beat.
REQ-013 ld_last  in  1  marks the final beat of the image.
REQ-014 mem_we  out  1  memory write strobe.
REQ-015 mem_addr  out  ADDR_W  memory write address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 cpu_clr  out  1  active-high reset driven to the CPU.
REQ-018 cpu_st_valid  in  1  CPU store snoop valid.
REQ-019 cpu_st_addr  in  ADDR_W  CPU store word address.
REQ-020 cpu_st_data  in  DATA_W  CPU store data.
REQ-021 start  in  1  run the resident image without reloading it.
REQ-022 busy  out  1  high in the LOAD, RESET and RUN states.
REQ-023 done  out  1  high in the DONE state.
REQ-024 pass  out  1  run ended with a tohost value of 1.
REQ-025 timeout  out  1  run ended because the cycle limit was reached.
REQ-026 cycles  out  CYC_W  number of RUN cycles in the last run.
REQ-027 exit_code  out  DATA_W  value stored to tohost.

Function
REQ-028 States: IDLE, LOAD, RESET, RUN, DONE.
REQ-029 ld_ready is high in IDLE, LOAD and DONE, and low in RESET and RUN.
REQ-030 Each accepted beat drives mem_we=1, mem_addr=ld_addr and mem_wdata=ld_data on the next cycle (one-cycle registered latency).
REQ-031 mem_we is 0 in every cycle that follows no accepted beat.
REQ-032 An accepted beat in IDLE or DONE enters LOAD; DONE additionally clears done, pass, timeout, exit_code and cycles.
REQ-033 An accepted beat with ld_last high moves to RESET, including a single-beat image accepted directly from IDLE or DONE.
REQ-034 start in IDLE or DONE with no accepted beat moves to RESET and clears the status outputs.
REQ-035 start is ignored in LOAD, RESET and RUN.
REQ-036 cpu_clr is high in every state except RUN.
REQ-037 RESET lasts exactly RST_CYCLES cycles, then the block enters RUN.
REQ-038 RUN clears cycles on entry and increments it once per RUN cycle.
REQ-039 In RUN, cpu_st_valid with cpu_st_addr==TOHOST_ADDR moves to DONE and registers exit_code=cpu_st_data and pass=(cpu_st_data==1).
REQ-040 In RUN, the cycle where cycles reaches TIMEOUT-1 without a tohost store moves to DONE with timeout=1 and pass=0.
REQ-041 When a tohost store and the timeout occur in the same cycle, the tohost store wins and timeout stays 0.
REQ-042 Stores to any other address are ignored; CPU stores outside RUN are ignored.
REQ-043 In DONE, all status outputs hold until the next load beat or start.

Reset
REQ-044 clr=0 at a rising edge forces IDLE in any state, including mid-load or mid-run.
REQ-045 Reset values: cpu_clr=1, mem_we=0, busy=0, done=0, pass=0, timeout=0, cycles=0, exit_code=0, mem_addr=0, mem_wdata=0.
REQ-046 A load beat presented in the reset cycle is not written to memory.

Structure
REQ-047 Package cpu_run_pkg holds the state enum and the default parameter constants.
REQ-048 Sub-module run_timer holds the CYC_W counter with clear, enable and terminal-count (==TIMEOUT-1) outputs.

Verification
REQ-049 Load 4 beats at addresses 0..3 (last on address 3) -> four mem_we pulses, each one cycle after acceptance; cpu_clr high for 2 cycles, then RUN.
REQ-050 In RUN, store 1 to 12'hFFF at RUN cycle 10 -> done=1, pass=1, exit_code=1, cycles=10, cpu_clr=1.
REQ-051 In RUN, store 7 to TOHOST -> pass=0 and exit_code=7; no store at all -> timeout=1 with cycles=99.
REQ-052 Tohost store in the same cycle as the TIMEOUT-1 terminal count -> timeout=0 and exit_code equals the stored value.
REQ-053 clr=0 during RUN cycle 5 -> IDLE on the next cycle with all reset values; a later start -> full RESET then RUN.
REQ-054 start from DONE -> status cleared, no mem_we pulses, and a new run completes.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg
//   Shared definitions for the CPU run controller: the controller state
//   encoding and the default values of its parameters.
package cpu_run_pkg;

    localparam int              DEF_ADDR_W      = 12;
    localparam int              DEF_DATA_W      = 32;
    localparam int              DEF_RST_CYCLES  = 2;
    localparam int              DEF_TIMEOUT     = 100;
    localparam int              DEF_CYC_W       = 32;
    localparam logic [11:0]     DEF_TOHOST_ADDR = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } run_state_t;

endpackage

// File: rtl/run_timer.sv
// run_timer
//   RUN-cycle counter with a terminal-count flag.
//   clk     : system clock, rising edge
//   clr     : synchronous active-low reset
//   clear   : zero the count on the next edge (wins over enable)
//   enable  : advance the count by one on the next edge
//   count   : current count
//   tc      : count has reached TIMEOUT-1
module run_timer #(
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 100
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CYC_W'(1);
        end
    end

    assign tc = (count == CYC_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Loads a program image into CPU memory, holds the CPU in reset for a
//   fixed number of cycles, runs it, and ends the run on a store to the
//   tohost address or when the cycle limit is reached.
//
//   clk, clr                    : clock, synchronous active-low reset
//   ld_valid/ready/addr/data/last : program-load beat handshake
//   mem_we/addr/wdata           : registered memory write port
//   cpu_clr                     : active-high CPU reset
//   cpu_st_valid/addr/data      : CPU store snoop
//   start                       : rerun the resident image
//   busy, done, pass, timeout   : run status
//   cycles, exit_code           : RUN cycle count and tohost value
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | out of reset, waiting for a load beat or start
//   LOAD     | accepting image beats until ld_last
//   RESET    | holding cpu_clr for RST_CYCLES cycles
//   RUN      | CPU released; watching for tohost store / timeout
//   DONE     | status held until the next load beat or start
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                RST_CYCLES  = DEF_RST_CYCLES,
    parameter int                TIMEOUT     = DEF_TIMEOUT,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEF_TOHOST_ADDR),
    parameter int                CYC_W       = DEF_CYC_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_clr,
    input  logic              cpu_st_valid,
    input  logic [ADDR_W-1:0] cpu_st_addr,
    input  logic [DATA_W-1:0] cpu_st_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles,
    output logic [DATA_W-1:0] exit_code
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t       state, state_next;
    logic [RST_W-1:0] rst_cnt;
    logic             accept;
    logic             status_clr;
    logic             st_hit;
    logic             to_hit;
    logic             tc;

    assign ld_ready = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE);
    assign accept   = ld_valid && ld_ready;
    assign cpu_clr  = (state != ST_RUN);
    assign busy     = (state == ST_LOAD) || (state == ST_RESET) || (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        status_clr = 1'b0;
        st_hit     = 1'b0;
        to_hit     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    status_clr = 1'b1;
                    state_next = ld_last ? ST_RESET : ST_LOAD;
                end else if (start) begin
                    status_clr = 1'b1;
                    state_next = ST_RESET;
                end
            end
            ST_LOAD: begin
                if (accept && ld_last) begin
                    state_next = ST_RESET;
                end
            end
            ST_RESET: begin
                if (rst_cnt == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // tohost is checked first so it wins a tie with the timeout
                if (cpu_st_valid && (cpu_st_addr == TOHOST_ADDR)) begin
                    st_hit     = 1'b1;
                    state_next = ST_DONE;
                end else if (tc) begin
                    to_hit     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reloaded whenever we are outside RESET, so it counts down from
    // RST_CYCLES-1 to 0 across the RESET window.
    always_ff @(posedge clk) begin
        if (!clr || (state != ST_RESET)) begin
            rst_cnt <= RST_W'(RST_CYCLES - 1);
        end else begin
            rst_cnt <= rst_cnt - RST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr || status_clr) begin
            pass      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else if (st_hit) begin
            pass      <= (cpu_st_data == DATA_W'(1));
            timeout   <= 1'b0;
            exit_code <= cpu_st_data;
        end else if (to_hit) begin
            pass      <= 1'b0;
            timeout   <= 1'b1;
        end
    end

    // The count freezes on the cycle that ends the run, so cycles reads
    // back the counter value seen when the run stopped.
    run_timer #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .clr    (clr),
        .clear  (status_clr || (state == ST_RESET)),
        .enable ((state == ST_RUN) && (state_next == ST_RUN)),
        .count  (cycles),
        .tc     (tc)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        ld_valid;
    logic        ld_ready;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_clr;
    logic        cpu_st_valid;
    logic [11:0] cpu_st_addr;
    logic [31:0] cpu_st_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] cycles;
    logic [31:0] exit_code;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_clr      (cpu_clr),
        .cpu_st_valid (cpu_st_valid),
        .cpu_st_addr  (cpu_st_addr),
        .cpu_st_data  (cpu_st_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .cycles       (cycles),
        .exit_code    (exit_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cpu_clr"},   cpu_clr,   1);
        chk({tag, "_mem_we"},    mem_we,    0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_pass"},      pass,      0);
        chk({tag, "_timeout"},   timeout,   0);
        chk({tag, "_cycles"},    cycles,    0);
        chk({tag, "_exit_code"}, exit_code, 0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ld_ready"},  ld_ready,  1);
    endtask

    // Call with start or a last beat already driven; returns in the first RUN cycle.
    task automatic start_run(input string tag, input bit first_we, input logic [11:0] we_addr);
        int n;
        n = 1;
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk({tag, "_clr_done"},    done,      0);
        chk({tag, "_clr_pass"},    pass,      0);
        chk({tag, "_clr_timeout"}, timeout,   0);
        chk({tag, "_clr_exit"},    exit_code, 0);
        chk({tag, "_clr_cycles"},  cycles,    0);
        chk({tag, "_busy"},        busy,      1);
        chk({tag, "_we_first"},    mem_we,    first_we);
        if (first_we) chk({tag, "_we_addr"}, mem_addr, we_addr);
        while (cpu_clr && n < 20) begin
            @(negedge clk);
            n++;
            chk({tag, "_we_idle"}, mem_we, 0);
        end
        chk({tag, "_reset_len"}, n, 3);
        chk({tag, "_run_cycles0"}, cycles, 0);
    endtask

    initial begin
        clr          = 1'b0;
        ld_valid     = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        ld_last      = 1'b0;
        cpu_st_valid = 1'b0;
        cpu_st_addr  = '0;
        cpu_st_data  = '0;
        start        = 1'b0;

        repeat (2) @(negedge clk);
        // beat offered during reset must not reach memory
        ld_valid = 1'b1;
        ld_addr  = 12'h005;
        ld_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_reset("rst");
        ld_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        chk("idle_we", mem_we, 0);
        chk("idle_busy", busy, 0);

        // four-beat image
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 12'(i);
            ld_data  = 32'hA5A5_0000 + 32'(i);
            ld_last  = (i == 3);
            @(negedge clk);
            chk("load_we",    mem_we,    1);
            chk("load_addr",  mem_addr,  i);
            chk("load_wdata", mem_wdata, 32'hA5A5_0000 + 32'(i));
            chk("load_busy",  busy,      1);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("rst1_cpu_clr",  cpu_clr,  1);
        chk("rst1_ld_ready", ld_ready, 0);
        @(negedge clk);
        chk("rst2_cpu_clr", cpu_clr, 1);
        chk("rst2_we",      mem_we,  0);
        @(negedge clk);
        chk("run_cpu_clr", cpu_clr, 0);
        chk("run_cycles0", cycles,  0);
        chk("run_busy",    busy,    1);

        // other-address store at cycle 3 is ignored; tohost=1 at cycle 10
        repeat (3) @(negedge clk);
        cpu_st_valid = 1'b1;
        cpu_st_addr  = 12'h010;
        cpu_st_data  = 32'd1;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("other_store_done", done, 0);
        repeat (6) @(negedge clk);
        chk("pre_store_cycles", cycles, 10);
        cpu_st_valid = 1'b1;
        cpu_st_addr  = 12'hFFF;
        cpu_st_data  = 32'd1;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("p1_done",    done,      1);
        chk("p1_pass",    pass,      1);
        chk("p1_exit",    exit_code, 1);
        chk("p1_cycles",  cycles,    10);
        chk("p1_cpu_clr", cpu_clr,   1);
        chk("p1_timeout", timeout,   0);
        chk("p1_busy",    busy,      0);
        @(negedge clk);
        chk("p1_hold_done",   done,   1);
        chk("p1_hold_cycles", cycles, 10);

        // start from DONE, store 7 on the first RUN cycle
        start = 1'b1;
        start_run("s7", 1'b0, 12'h000);
        cpu_st_valid = 1'b1;
        cpu_st_data  = 32'd7;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("s7_done",   done,      1);
        chk("s7_pass",   pass,      0);
        chk("s7_exit",   exit_code, 7);
        chk("s7_cycles", cycles,    0);

        // timeout run, with a start pulse in RUN that must be ignored
        start = 1'b1;
        start_run("to", 1'b0, 12'h000);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_cpu_clr", cpu_clr, 0);
        chk("ign_start_cycles",  cycles,  3);
        repeat (96) @(negedge clk);
        chk("to_pre_cycles", cycles, 99);
        chk("to_pre_done",   done,   0);
        @(negedge clk);
        chk("to_done",    done,      1);
        chk("to_timeout", timeout,   1);
        chk("to_pass",    pass,      0);
        chk("to_cycles",  cycles,    99);
        chk("to_exit",    exit_code, 0);
        // store outside RUN is ignored
        cpu_st_valid = 1'b1;
        cpu_st_data  = 32'd1;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("done_store_exit", exit_code, 0);
        chk("done_store_pass", pass,      0);

        // tohost and terminal count in the same cycle
        start = 1'b1;
        start_run("tie", 1'b0, 12'h000);
        repeat (99) @(negedge clk);
        cpu_st_valid = 1'b1;
        cpu_st_data  = 32'd5;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("tie_done",    done,      1);
        chk("tie_timeout", timeout,   0);
        chk("tie_exit",    exit_code, 5);
        chk("tie_pass",    pass,      0);
        chk("tie_cycles",  cycles,    99);

        // single-beat image straight from DONE, then reset mid-run
        ld_valid = 1'b1;
        ld_addr  = 12'h009;
        ld_data  = 32'h1234_5678;
        ld_last  = 1'b1;
        start_run("one", 1'b1, 12'h009);
        repeat (5) @(negedge clk);
        chk("mid_cycles", cycles, 5);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk_reset("midrst");
        @(negedge clk);
        chk("midrst_idle_busy", busy, 0);
        start = 1'b1;
        start_run("rs", 1'b0, 12'h000);
        cpu_st_valid = 1'b1;
        cpu_st_data  = 32'd1;
        @(negedge clk);
        cpu_st_valid = 1'b0;
        chk("rs_done", done, 1);
        chk("rs_pass", pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
